// File: rtl/jk_cell_arbiter_if.sv
// Requester-side command/response bundle for jk_cell_arbiter.
// Two requesters share the signals; bit r (or slice r) belongs to requester r.
interface jk_cell_arbiter_if #(
    parameter int unsigned IDX_W = 3
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [3:0]         req_op;
    logic [2*IDX_W-1:0] req_idx;
    logic [1:0]         rsp_valid;
    logic               rsp_q;
    logic               rsp_err;

    modport master (
        output req_valid, req_op, req_idx,
        input  req_ready, rsp_valid, rsp_q, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_idx,
        output req_ready, rsp_valid, rsp_q, rsp_err
    );
endinterface

// File: rtl/jk_cell_arbiter.sv
// Two-requester round-robin arbiter driving the J/K pins of a bank of
// master-slave JK cells for one clock per command and returning settled Q.
module jk_cell_arbiter #(
    parameter int unsigned N_CELLS = 6,
    parameter int unsigned IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    jk_cell_arbiter_if.slave   bus,
    output logic               busy,
    output logic [N_CELLS-1:0] jk_j,
    output logic [N_CELLS-1:0] jk_k,
    input  logic [N_CELLS-1:0] cell_q
);

    localparam int unsigned IDX_SPAN = 1 << IDX_W;
    localparam logic [IDX_W:0] CELL_LIMIT = (IDX_W+1)'(N_CELLS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic                 r_gnt, w_gnt_nxt;
    logic                 r_in_range, w_in_range_nxt;
    logic                 r_prio, w_prio_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [N_CELLS-1:0]   r_jk_j, w_jk_j_nxt;
    logic [N_CELLS-1:0]   r_jk_k, w_jk_k_nxt;
    logic [1:0]           r_rsp_valid, w_rsp_valid_nxt;
    logic                 r_rsp_q, w_rsp_q_nxt;
    logic                 r_rsp_err, w_rsp_err_nxt;

    logic                 w_any_valid;
    logic                 w_grant;
    logic                 w_hs;
    logic [1:0]           w_op_in;
    logic [IDX_W-1:0]     w_idx_in;
    logic                 w_in_range_in;
    logic [N_CELLS-1:0]   w_onehot;
    logic [IDX_SPAN-1:0]  w_q_pad;

    // Grant: single requester wins outright, contention resolved by prio.
    always_comb begin
        w_grant = 1'b0;
        case (bus.req_valid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = r_prio;
            default: w_grant = 1'b0;
        endcase
    end

    assign w_any_valid   = |bus.req_valid;
    assign w_hs          = rst_n && (r_state == ST_IDLE) && w_any_valid;
    assign w_op_in       = w_grant ? bus.req_op[3:2] : bus.req_op[1:0];
    assign w_idx_in      = w_grant ? bus.req_idx[2*IDX_W-1:IDX_W] : bus.req_idx[IDX_W-1:0];
    assign w_in_range_in = {1'b0, w_idx_in} < CELL_LIMIT;
    assign w_onehot      = N_CELLS'(1) << w_idx_in;
    // Padding lets an out-of-range index select a harmless zero bit.
    assign w_q_pad       = IDX_SPAN'(cell_q);

    assign bus.req_ready = w_hs ? {w_grant, ~w_grant} : 2'b00;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_q     = r_rsp_q;
    assign bus.rsp_err   = r_rsp_err;
    assign busy          = r_busy;
    assign jk_j          = r_jk_j;
    assign jk_k          = r_jk_k;

    // Next-state and registered-output decode; J/K default to idle-low.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_gnt_nxt       = r_gnt;
        w_in_range_nxt  = r_in_range;
        w_prio_nxt      = r_prio;
        w_jk_j_nxt      = '0;
        w_jk_k_nxt      = '0;
        w_rsp_valid_nxt = 2'b00;
        w_rsp_q_nxt     = r_rsp_q;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_nxt    = ST_ISSUE;
                    w_idx_nxt      = w_idx_in;
                    w_gnt_nxt      = w_grant;
                    w_in_range_nxt = w_in_range_in;
                    w_prio_nxt     = ~w_grant;
                    if (w_in_range_in) begin
                        w_jk_j_nxt = w_onehot & {N_CELLS{w_op_in[1]}};
                        w_jk_k_nxt = w_onehot & {N_CELLS{w_op_in[0]}};
                    end
                end
            end
            ST_ISSUE: w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                w_state_nxt     = ST_RESP;
                w_rsp_valid_nxt = {r_gnt, ~r_gnt};
                w_rsp_q_nxt     = r_in_range & w_q_pad[r_idx];
                w_rsp_err_nxt   = ~r_in_range;
            end
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_gnt       <= 1'b0;
            r_in_range  <= 1'b0;
            r_prio      <= 1'b0;
            r_busy      <= 1'b0;
            r_jk_j      <= '0;
            r_jk_k      <= '0;
            r_rsp_valid <= 2'b00;
            r_rsp_q     <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_gnt       <= w_gnt_nxt;
            r_in_range  <= w_in_range_nxt;
            r_prio      <= w_prio_nxt;
            r_busy      <= w_busy_nxt;
            r_jk_j      <= w_jk_j_nxt;
            r_jk_k      <= w_jk_k_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_q     <= w_rsp_q_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_jk_cell_arbiter.sv
// Directed bench for jk_cell_arbiter with a behavioural master-slave JK bank.
module tb_jk_cell_arbiter;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [5:0] jk_j;
    logic [5:0] jk_k;
    logic [5:0] cell_m = '0;
    logic [5:0] cell_q = '0;
    int         jk_edges = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    jk_cell_arbiter_if #(.IDX_W(3)) bus_if ();

    jk_cell_arbiter #(.N_CELLS(6), .IDX_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_if.slave),
        .busy   (busy),
        .jk_j   (jk_j),
        .jk_k   (jk_k),
        .cell_q (cell_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Master captures on posedge, slave follows on negedge.
    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            case ({jk_j[i], jk_k[i]})
                2'b01:   cell_m[i] <= 1'b0;
                2'b10:   cell_m[i] <= 1'b1;
                2'b11:   cell_m[i] <= ~cell_q[i];
                default: cell_m[i] <= cell_q[i];
            endcase
        end
        if (|(jk_j | jk_k)) jk_edges <= jk_edges + 1;
    end

    always @(negedge clk) cell_q <= cell_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one command from IDLE and checks every stage of its 4-cycle walk.
    task automatic do_cmd(input int r, input logic [1:0] op, input logic [2:0] idx,
                          input logic [5:0] ej, input logic [5:0] ek,
                          input logic eq, input logic ee, input int eedges,
                          input string tag);
        int e0;
        bus_if.req_valid = 2'b00;
        bus_if.req_valid[r] = 1'b1;
        bus_if.req_op[2*r +: 2] = op;
        bus_if.req_idx[3*r +: 3] = idx;
        #1;
        chk({tag, ".ready"}, 32'(bus_if.req_ready), 32'(2'b01 << r));
        e0 = jk_edges;
        tick();
        bus_if.req_valid = 2'b00;
        chk({tag, ".issue_j"}, 32'(jk_j), 32'(ej));
        chk({tag, ".issue_k"}, 32'(jk_k), 32'(ek));
        chk({tag, ".issue_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, ".settle_jk"}, 32'({jk_j, jk_k}), 32'd0);
        chk({tag, ".settle_rv"}, 32'(bus_if.rsp_valid), 32'd0);
        tick();
        chk({tag, ".resp_rv"}, 32'(bus_if.rsp_valid), 32'(2'b01 << r));
        chk({tag, ".resp_q"}, 32'(bus_if.rsp_q), 32'(eq));
        chk({tag, ".resp_err"}, 32'(bus_if.rsp_err), 32'(ee));
        tick();
        chk({tag, ".idle_rv"}, 32'(bus_if.rsp_valid), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".jk_edges"}, 32'(jk_edges - e0), 32'(eedges));
    endtask

    initial begin
        logic [5:0] q_before;
        rst_n = 1'b0;
        bus_if.req_valid = 2'b11;
        bus_if.req_op    = 4'b1010;
        bus_if.req_idx   = {3'd1, 3'd0};
        tick();
        tick();
        chk("rst.ready", 32'(bus_if.req_ready), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.jk", 32'({jk_j, jk_k}), 32'd0);
        chk("rst.rv", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst.q_err", 32'({bus_if.rsp_q, bus_if.rsp_err}), 32'd0);

        // Contention: both requesters held valid from reset, grants alternate from 0.
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cont%0d.ready", k), 32'(bus_if.req_ready), 32'(2'b01 << (k % 2)));
            tick();
            chk($sformatf("cont%0d.ready_issue", k), 32'(bus_if.req_ready), 32'd0);
            chk($sformatf("cont%0d.busy", k), 32'(busy), 32'd1);
            tick();
            chk($sformatf("cont%0d.ready_settle", k), 32'(bus_if.req_ready), 32'd0);
            tick();
            chk($sformatf("cont%0d.rv", k), 32'(bus_if.rsp_valid), 32'(2'b01 << (k % 2)));
            chk($sformatf("cont%0d.q", k), 32'(bus_if.rsp_q), 32'd1);
            tick();
        end
        bus_if.req_valid = 2'b00;
        chk("cont.cells", 32'(cell_q[1:0]), 32'd3);

        do_cmd(0, 2'b10, 3'd3, 6'b001000, 6'b000000, 1'b1, 1'b0, 1, "set3");
        chk("set3.cell", 32'(cell_q[3]), 32'd1);

        do_cmd(1, 2'b11, 3'd2, 6'b000100, 6'b000100, 1'b1, 1'b0, 1, "tog2a");
        do_cmd(1, 2'b11, 3'd2, 6'b000100, 6'b000100, 1'b0, 1'b0, 1, "tog2b");
        do_cmd(1, 2'b00, 3'd2, 6'b000000, 6'b000000, 1'b0, 1'b0, 0, "rd2");
        do_cmd(1, 2'b01, 3'd3, 6'b000000, 6'b001000, 1'b0, 1'b0, 1, "clr3");

        q_before = cell_q;
        do_cmd(0, 2'b11, 3'd7, 6'b000000, 6'b000000, 1'b0, 1'b1, 0, "oor7");
        chk("oor7.cells", 32'(cell_q), 32'(q_before));
        do_cmd(0, 2'b00, 3'd0, 6'b000000, 6'b000000, 1'b1, 1'b0, 0, "rd0_err_clr");

        // Withdrawn request: requester 1 pulses valid only while busy.
        bus_if.req_valid = 2'b01;
        bus_if.req_op    = 4'b1010;
        bus_if.req_idx   = {3'd5, 3'd4};
        #1;
        chk("wd.ready0", 32'(bus_if.req_ready), 32'd1);
        tick();
        bus_if.req_valid = 2'b10;
        #1;
        chk("wd.ready_issue", 32'(bus_if.req_ready), 32'd0);
        tick();
        chk("wd.ready_settle", 32'(bus_if.req_ready), 32'd0);
        tick();
        bus_if.req_valid = 2'b00;
        chk("wd.rv", 32'(bus_if.rsp_valid), 32'd1);
        chk("wd.q", 32'(bus_if.rsp_q), 32'd1);
        tick();
        tick();
        tick();
        chk("wd.busy", 32'(busy), 32'd0);
        chk("wd.cells", 32'(cell_q[5:4]), 32'b01);

        // Reset during SETTLE of a set issued by requester 0 (prio becomes 1).
        bus_if.req_valid = 2'b01;
        bus_if.req_op    = 4'b1010;
        bus_if.req_idx   = {3'd0, 3'd5};
        tick();
        bus_if.req_valid = 2'b00;
        chk("rstmid.issue_j", 32'(jk_j), 32'b100000);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rstmid.rv", 32'(bus_if.rsp_valid), 32'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.q", 32'(bus_if.rsp_q), 32'd0);
        chk("rstmid.cell5", 32'(cell_q[5]), 32'd1);
        tick();
        chk("rstmid.rv2", 32'(bus_if.rsp_valid), 32'd0);
        rst_n = 1'b1;
        bus_if.req_valid = 2'b11;
        bus_if.req_op    = 4'b0000;
        bus_if.req_idx   = {3'd0, 3'd5};
        #1;
        chk("rstmid.prio", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid = 2'b00;
        do_cmd(0, 2'b00, 3'd5, 6'b000000, 6'b000000, 1'b1, 1'b0, 0, "rd5");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
